rca_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-sharing one external 4-bit ripple-carry adder (a, b, cin → sum, cout). The block accepts an operand pair over a valid/ready handshake and steps through the operands one nibble per cycle, LSB first. It chains the carry through a register and returns the full-width result over a second valid/ready handshake. It sits between the operand source and the shared 4-bit RCA, which it drives exclusively while busy.

---
 rtl/rca_seq_ctrl.sv | 112 +++++++++++
 tb/tb_rca_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Sequences a WIDTH-bit add/subtract through one shared external 4-bit ripple-carry adder,
// one nibble per cycle LSB first, with valid/ready handshakes on operands and result.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy,
    output logic [3:0]       rca_a,
    output logic [3:0]       rca_b,
    output logic             rca_cin,
    input  logic [3:0]       rca_sum,
    input  logic             rca_cout
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_run;
    logic [KW+1:0]    w_base;

    assign w_run  = (r_state == S_RUN);
    assign w_base = {r_k, 2'b00};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so the forced carry-in replaces in_cin.
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub | in_cin;
                        r_k     <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 4] <= rca_sum;
                    r_carry            <= rca_cout;
                    if (r_k == KW'(N - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is held low during reset even though the state register already reads IDLE.
    assign in_ready  = reset_n & (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_out_valid ? r_sum : '0;
    assign out_cout  = r_out_valid & r_carry;
    assign out_ovf   = r_out_valid & (r_a[WIDTH-1] == r_b[WIDTH-1])
                                   & (r_sum[WIDTH-1] != r_a[WIDTH-1]);

    assign rca_a   = w_run ? r_a[w_base +: 4] : 4'h0;
    assign rca_b   = w_run ? r_b[w_base +: 4] : 4'h0;
    assign rca_cin = w_run & r_carry;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: behavioural 4-bit RCA, directed plan cases plus random operations
// checked against a whole-word arithmetic reference model.
module tb_rca_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;
    logic [3:0]       rca_a;
    logic [3:0]       rca_b;
    logic             rca_cin;
    logic [3:0]       rca_sum;
    logic             rca_cout;

    int n_chk  = 0;
    int n_fail = 0;

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .rca_a     (rca_a),
        .rca_b     (rca_b),
        .rca_cin   (rca_cin),
        .rca_sum   (rca_sum),
        .rca_cout  (rca_cout)
    );

    always #5 clk = ~clk;

    assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0, rca_cin};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic on the whole words.
    function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
        int     sa, sb, sres;
        longint ua, ub, ures;
        logic   cout, ovf;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            ures = ua - ub;
            cout = (ua >= ub);
            sres = sa - sb;
        end else begin
            ures = ua + ub + longint'(cin);
            cout = (ures >= 65536);
            sres = sa + sb + int'(cin);
        end
        ovf = (sres > 32767) || (sres < -32768);
        return {ovf, cout, ures[15:0]};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input int hold);
        logic [17:0] exp;
        int          n;
        int          lat;
        logic [17:0] snap;
        exp = ref_op(a, b, cin, sub);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before", in_ready, 1);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_cin   = 1'($urandom);
        in_sub   = 1'($urandom);
        chk("busy_run", busy, 1);
        chk("in_ready_run", in_ready, 0);
        chk("rca_a_k0", rca_a, a[3:0]);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 4);
        chk("sum", out_sum, exp[15:0]);
        chk("cout", out_cout, exp[16]);
        chk("ovf", out_ovf, exp[17]);
        snap = {out_ovf, out_cout, out_sum};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", {out_ovf, out_cout, out_sum}, snap);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_rca", {rca_a, rca_b, rca_cin}, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out", {out_ovf, out_cout, out_sum}, 0);
        chk("rst_rca", {rca_a, rca_b, rca_cin}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, 5);

        // Abort mid-RUN at k=2.
        @(negedge clk);
        in_a     = 16'hABCD;
        in_b     = 16'h1111;
        in_cin   = 1'b0;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_rca_a_k2", rca_a, 4'hB);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rca", {rca_a, rca_b, rca_cin}, 0);
        chk("abort_in_ready_low", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("abort_in_ready_rel", in_ready, 1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
